// File: rtl/neo_wram_bridge.sv
// Work-RAM bridge: turns 68000 work-RAM bus cycles into single-word req/ack memory transactions with a registered DTACK.
// Optional one-word read cache is enabled by defining WRAM_READ_CACHE_EN.
module neo_wram_bridge #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        nAS,
  input  logic        RW,
  input  logic        nLDS,
  input  logic        nUDS,
  input  logic        nWRAM_ZONE,
  input  logic [15:1] M68K_ADDR,
  input  logic [15:0] M68K_DIN,
  output logic [15:0] M68K_DOUT,
  output logic        nWRAM_DTACK,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [1:0]  MEM_BE,
  output logic [14:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        WRAM_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_DRAIN} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        abort_q, abort_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] dout_q, dout_d;
  logic        dtack_n_q, dtack_n_d;
  logic        err_q, err_d;
  logic        start, timeout;
  logic        cache_hit;
  logic [15:0] cache_data;

  assign start   = !nAS && !nWRAM_ZONE && (!nLDS || !nUDS);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  // Timeout fires in the TIMEOUT-th REQ cycle, so MEM_REQ is high exactly TIMEOUT cycles.
  assign timeout = (state_q == S_REQ) && !MEM_ACK && (cnt_inc == TIMEOUT_C);

`ifdef WRAM_READ_CACHE_EN
  logic [14:0] tag_q, tag_d;
  logic [15:0] cdata_q, cdata_d;
  logic        cvalid_q, cvalid_d;

  assign cache_hit  = cvalid_q && (tag_q == M68K_ADDR);
  assign cache_data = cdata_q;

  always_comb begin
    tag_d    = tag_q;
    cdata_d  = cdata_q;
    cvalid_d = cvalid_q;
    if (state_q == S_IDLE && start && !RW && cache_hit) begin
      if (!nUDS) cdata_d[15:8] = M68K_DIN[15:8];
      if (!nLDS) cdata_d[7:0]  = M68K_DIN[7:0];
    end
    if (state_q == S_REQ && MEM_ACK && !mem_we_q && mem_be_q == 2'b11) begin
      tag_d    = mem_addr_q;
      cdata_d  = MEM_RDATA;
      cvalid_d = 1'b1;
    end else if (timeout) begin
      cvalid_d = 1'b0;
    end
  end

  // NOTE: the tag and data are reset along with the valid bit; only valid matters, but a fully reset cache keeps simulation X-free.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      tag_q    <= '0;
      cdata_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      cdata_q  <= cdata_d;
      cvalid_q <= cvalid_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 16'h0000;
`endif

  // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dout_d      = dout_q;
    dtack_n_d   = dtack_n_q;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_we_d    = ~RW;
          mem_be_d    = {~nUDS, ~nLDS};
          mem_addr_d  = M68K_ADDR;
          mem_wdata_d = M68K_DIN;
          if (RW && cache_hit) begin
            state_d   = S_DONE;
            dout_d    = cache_data;
            dtack_n_d = 1'b0;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
            cnt_d     = 8'd0;
            abort_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (nAS) abort_d = 1'b1;
        if (MEM_ACK || timeout) begin
          mem_req_d = 1'b0;
          if (MEM_ACK) begin
            if (!mem_we_q) dout_d = MEM_RDATA;
          end else begin
            dout_d = 16'hFFFF;
            err_d  = 1'b1;
          end
          // An abandoned CPU cycle still waits out its request but never gets DTACK.
          if (abort_q || nAS) begin
            state_d = S_DRAIN;
          end else begin
            state_d   = S_DONE;
            dtack_n_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (nAS) begin
          state_d   = S_IDLE;
          dtack_n_d = 1'b1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dout_q      <= '0;
      dtack_n_q   <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dout_q      <= dout_d;
      dtack_n_q   <= dtack_n_d;
      err_q       <= err_d;
    end
  end

  assign M68K_DOUT   = dout_q;
  assign nWRAM_DTACK = dtack_n_q;
  assign MEM_REQ     = mem_req_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_BE      = mem_be_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign WRAM_ERR    = err_q;

endmodule
